// File: rtl/tx_buffer_pkg.sv
// Shared types and constants for the UART transmit byte buffer.
package tx_buffer_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } tx_buffer_state_t;

endpackage

// File: rtl/tx_buffer_mem.sv
// DEPTH x BYTE_W storage: one synchronous write port, one combinational read port.
module tx_buffer_mem
  import tx_buffer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [BYTE_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [BYTE_W-1:0] rdata
);

  logic [BYTE_W-1:0] mem [DEPTH];

  // NOTE: the array has no reset; entries are only read after being written,
  // so resetting them would just cost flops and block RAM inference.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/tx_buffer.sv
// Byte FIFO feeding the UART transmit frontend: one registered request per byte,
// next request held until the frontend reports frame completion.
// Optional feature macro: TX_BUFFER_THRESHOLD_EN (adds thr_i / thr_o level flag).
module tx_buffer
  import tx_buffer_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_i,
  input  logic [BYTE_W-1:0] wdata_i,
  input  logic              flush_i,
  input  logic              ovf_clr_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [AW:0]       count_o,
  output logic              overflow_o,
  output logic              transmit_o,
  output logic [BYTE_W-1:0] dr_o,
  input  logic              done_i,
`ifdef TX_BUFFER_THRESHOLD_EN
  input  logic [AW:0]       thr_i,
  output logic              thr_o,
`endif
  output logic              busy_o
);

  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  tx_buffer_state_t  state, state_next;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count, count_next;
  logic              pop, accept, drop;
  logic [BYTE_W-1:0] rd_data;

  assign full_o  = (count == FULL_COUNT);
  assign empty_o = (count == '0);
  assign count_o = count;
  assign busy_o  = (state != IDLE);

  // A full buffer still takes a write when the head leaves in the same cycle.
  assign pop    = (state == REQ) && !empty_o && !flush_i;
  assign accept = wr_i && !flush_i && (!full_o || pop);
  assign drop   = wr_i && !flush_i && full_o && !pop;

  tx_buffer_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk_i),
    .we    (accept),
    .waddr (wr_ptr),
    .wdata (wdata_i),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    count_next = count;
    if (flush_i) begin
      count_next = '0;
    end else begin
      case ({accept, pop})
        2'b10:   count_next = count + CNT_ONE;
        2'b01:   count_next = count - CNT_ONE;
        default: count_next = count;
      endcase
    end
  end

  // A flush in the same cycle suppresses the request so a discarded byte is never sent.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (!empty_o && !flush_i) state_next = REQ;
      REQ:     state_next = WAIT;
      WAIT:    if (done_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_o <= 1'b0;
      transmit_o <= 1'b0;
      dr_o       <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (flush_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (accept) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)    rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (drop)           overflow_o <= 1'b1;
      else if (ovf_clr_i) overflow_o <= 1'b0;
      transmit_o <= (state_next == REQ);
      if (state_next == REQ) dr_o <= rd_data;
    end
  end

`ifdef TX_BUFFER_THRESHOLD_EN
  // Compared against the next count so thr_o tracks count_o without a cycle of lag.
  always_ff @(posedge clk_i) begin
    if (rst_i) thr_o <= 1'b1;
    else       thr_o <= (count_next <= thr_i);
  end
`endif

endmodule
